// File: rtl/bus_burst_ram_slave.sv
// Single-port word RAM behind a burst-bus slave: one decoded window, burst reads after
// a fixed number of wait states, byte-enabled burst writes with an optional stall pattern.
module bus_burst_ram_slave #(
    parameter logic [31:0] BASE_ADDRESS  = 32'h5000_0000,
    parameter int          NR_WORDS_LOG2 = 10,
    parameter int          WAIT_STATES   = 1,
    parameter int          BUSY_PERIOD   = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic [31:0] addressDataIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut
);

    localparam int NR_WORDS = 2 ** NR_WORDS_LOG2;
    localparam int IDX_W    = NR_WORDS_LOG2;
    localparam int SUM_W    = NR_WORDS_LOG2 + 1;
    localparam int SEL_LSB  = NR_WORDS_LOG2 + 2;
    localparam int WAIT_W   = $clog2(WAIT_STATES + 2);
    localparam int BUSY_W   = $clog2(BUSY_PERIOD + 2);

    localparam logic [IDX_W-1:0]  PTR_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [BUSY_W-1:0] BUSY_ONE  = {{(BUSY_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES - 1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ_WAIT  = 3'd1,
        READ_BURST = 3'd2,
        READ_END   = 3'd3,
        WRITE      = 3'd4,
        ERROR_END  = 3'd5
    } state_t;

    state_t            state_r;
    logic [31:0]       mem_r [NR_WORDS];
    logic [IDX_W-1:0]  ptr_r;
    logic [7:0]        burst_r;
    logic [8:0]        beat_cnt_r;
    logic [3:0]        be_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [BUSY_W-1:0] busy_cnt_r;
    logic [31:0]       rd_data_r;
    logic              dv_r;
    logic              end_r;
    logic              err_r;
    logic              busy_r;

    logic              sel_s;
    logic [IDX_W-1:0]  idx_s;
    logic [SUM_W-1:0]  last_s;
    logic              over_s;
    logic [8:0]        nr_beats_s;
    logic              accept_s;
    logic              wr_en_s;

    // Address decode, range check and write-beat acceptance.
    always_comb begin
        sel_s      = (addressDataIn[31:SEL_LSB] == BASE_ADDRESS[31:SEL_LSB]);
        idx_s      = addressDataIn[SEL_LSB-1:2];
        last_s     = {1'b0, idx_s} + SUM_W'(burstSizeIn);
        over_s     = last_s[SUM_W-1];
        nr_beats_s = {1'b0, burst_r} + 9'd1;
        accept_s   = (state_r == WRITE) && dataValidIn && !busy_r;
        // Beats beyond the burst length are accepted on the bus but never stored.
        wr_en_s    = accept_s && (beat_cnt_r < nr_beats_s) && !reset;
    end

    // Byte-lane RAM writes; contents are deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem_r[ptr_r][8*i +: 8] <= addressDataIn[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered bus outputs; outputs default to 0 every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            burst_r    <= 8'd0;
            beat_cnt_r <= 9'd0;
            be_r       <= 4'd0;
            wait_cnt_r <= '0;
            busy_cnt_r <= '0;
            rd_data_r  <= 32'd0;
            dv_r       <= 1'b0;
            end_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            rd_data_r <= 32'd0;
            dv_r      <= 1'b0;
            end_r     <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (beginTransactionIn && sel_s) begin
                        ptr_r      <= idx_s;
                        burst_r    <= burstSizeIn;
                        be_r       <= byteEnablesIn;
                        beat_cnt_r <= 9'd0;
                        wait_cnt_r <= '0;
                        busy_cnt_r <= '0;
                        if (over_s) begin
                            state_r <= ERROR_END;
                            end_r   <= 1'b1;
                            err_r   <= 1'b1;
                        end else if (readNotWriteIn) begin
                            state_r <= READ_WAIT;
                        end else begin
                            state_r <= WRITE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ_WAIT: begin
                    if (endTransactionIn) begin
                        state_r <= IDLE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // The RAM read lands in the output register: first beat next cycle.
                        state_r    <= READ_BURST;
                        dv_r       <= 1'b1;
                        rd_data_r  <= mem_r[ptr_r];
                        ptr_r      <= ptr_r + PTR_ONE;
                        beat_cnt_r <= 9'd1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                READ_BURST: begin
                    if (endTransactionIn) begin
                        state_r <= IDLE;
                    end else if (beat_cnt_r == nr_beats_s) begin
                        state_r <= READ_END;
                        end_r   <= 1'b1;
                    end else begin
                        dv_r       <= 1'b1;
                        rd_data_r  <= mem_r[ptr_r];
                        ptr_r      <= ptr_r + PTR_ONE;
                        beat_cnt_r <= beat_cnt_r + 9'd1;
                    end
                end
                READ_END: begin
                    state_r <= IDLE;
                end
                WRITE: begin
                    if (wr_en_s) begin
                        ptr_r      <= ptr_r + PTR_ONE;
                        beat_cnt_r <= beat_cnt_r + 9'd1;
                    end
                    if ((BUSY_PERIOD > 0) && accept_s && !endTransactionIn) begin
                        if (busy_cnt_r == BUSY_LAST) begin
                            busy_r     <= 1'b1;
                            busy_cnt_r <= '0;
                        end else begin
                            busy_cnt_r <= busy_cnt_r + BUSY_ONE;
                        end
                    end
                    if (endTransactionIn) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                ERROR_END: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign addressDataOut    = rd_data_r;
    assign dataValidOut      = dv_r;
    assign endTransactionOut = end_r;
    assign busErrorOut       = err_r;
    assign busyOut           = busy_r;

endmodule

// File: tb/tb_bus_burst_ram_slave.sv
// Directed bench for bus_burst_ram_slave: one default instance plus one with a write stall pattern.
module tb_bus_burst_ram_slave;

    logic        clock;
    logic        reset;
    logic        begin_a;
    logic        begin_b;
    logic        end_in;
    logic        rnw;
    logic        dv_in;
    logic [3:0]  be_in;
    logic [7:0]  burst_in;
    logic [31:0] ad_in;

    logic [31:0] data_a, data_b;
    logic        dv_a, dv_b, end_a, end_b, err_a, err_b, busy_a, busy_b;

    bit          use_b;
    logic [31:0] data_o;
    logic        dv_o, end_o, err_o, busy_o;

    assign data_o = use_b ? data_b : data_a;
    assign dv_o   = use_b ? dv_b   : dv_a;
    assign end_o  = use_b ? end_b  : end_a;
    assign err_o  = use_b ? err_b  : err_a;
    assign busy_o = use_b ? busy_b : busy_a;

    bus_burst_ram_slave dut (
        .clock(clock), .reset(reset), .beginTransactionIn(begin_a), .endTransactionIn(end_in),
        .readNotWriteIn(rnw), .dataValidIn(dv_in), .byteEnablesIn(be_in), .burstSizeIn(burst_in),
        .addressDataIn(ad_in), .addressDataOut(data_a), .dataValidOut(dv_a),
        .endTransactionOut(end_a), .busErrorOut(err_a), .busyOut(busy_a)
    );

    bus_burst_ram_slave #(.BUSY_PERIOD(2)) dut_busy (
        .clock(clock), .reset(reset), .beginTransactionIn(begin_b), .endTransactionIn(end_in),
        .readNotWriteIn(rnw), .dataValidIn(dv_in), .byteEnablesIn(be_in), .burstSizeIn(burst_in),
        .addressDataIn(ad_in), .addressDataOut(data_b), .dataValidOut(dv_b),
        .endTransactionOut(end_b), .busErrorOut(err_b), .busyOut(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [8];
    logic [31:0] wdat  [6];
    int          beat_tbl [8] = '{0, 1, 2, 2, 3, 4, 4, 5};
    logic [7:0]  busy_pat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, data_o | {28'd0, dv_o, end_o, err_o, busy_o}, 32'd0);
    endtask

    task automatic set_begin(input logic v);
        if (use_b) begin_b = v;
        else       begin_a = v;
    endtask

    // Burst read of nbeats words; expects exp_q[0..nbeats-1] starting one cycle after the wait.
    task automatic do_read(input logic [31:0] addr, input int nbeats, input string tag);
        set_begin(1'b1); rnw = 1'b1; burst_in = 8'(nbeats - 1); be_in = 4'hF; ad_in = addr;
        @(negedge clock);
        set_begin(1'b0); rnw = 1'b0; ad_in = 32'd0;
        chk({tag, "_wait"}, {31'd0, dv_o}, 32'd0);
        for (int k = 0; k < nbeats; k++) begin
            @(negedge clock);
            chk({tag, "_dv"}, {31'd0, dv_o}, 32'd1);
            chk({tag, "_data"}, data_o, exp_q[k]);
        end
        @(negedge clock);
        chk({tag, "_end"}, {30'd0, end_o, dv_o}, 32'd2);
        @(negedge clock);
        chk_idle({tag, "_idle"});
    endtask

    // Burst write of exp_q[0..nbeats-1]; the last beat coincides with endTransactionIn.
    task automatic do_write(input logic [31:0] addr, input int nbeats, input logic [3:0] be,
                            input string tag);
        set_begin(1'b1); rnw = 1'b0; burst_in = 8'(nbeats - 1); be_in = be; ad_in = addr;
        @(negedge clock);
        set_begin(1'b0);
        for (int k = 0; k < nbeats; k++) begin
            chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
            dv_in = 1'b1; ad_in = exp_q[k]; end_in = (k == nbeats - 1);
            @(negedge clock);
        end
        dv_in = 1'b0; end_in = 1'b0; ad_in = 32'd0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        use_b = 1'b0; reset = 1'b1; begin_a = 1'b0; begin_b = 1'b0; end_in = 1'b0;
        rnw = 1'b0; dv_in = 1'b0; be_in = 4'h0; burst_in = 8'd0; ad_in = 32'd0;
        busy_pat = 8'b0010_0100;
        for (int k = 0; k < 6; k++) wdat[k] = 32'hA000_0001 + 32'(k);
        repeat (3) @(negedge clock);
        chk_idle("reset_a");
        use_b = 1'b1; chk_idle("reset_b"); use_b = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        // 1: four-beat write then read back
        exp_q[0] = 32'h1111_1111; exp_q[1] = 32'h2222_2222;
        exp_q[2] = 32'h3333_3333; exp_q[3] = 32'h4444_4444;
        do_write(32'h5000_0010, 4, 4'hF, "t1_wr");
        do_read(32'h5000_0010, 4, "t1_rd");

        // 2: partial byte enables over word 4
        exp_q[0] = 32'hAABB_CCDD;
        do_write(32'h5000_0010, 1, 4'b0101, "t2_wr");
        exp_q[0] = 32'h11BB_11DD;
        do_read(32'h5000_0010, 4, "t2_rd");

        // 3: last word is writable alone, a 2-beat burst there errors
        exp_q[0] = 32'h1234_5678;
        do_write(32'h5000_0FFC, 1, 4'hF, "t3_wr");
        set_begin(1'b1); rnw = 1'b0; burst_in = 8'd1; be_in = 4'hF; ad_in = 32'h5000_0FFC;
        @(negedge clock);
        set_begin(1'b0);
        chk("t3_err", {29'd0, err_o, end_o, dv_o}, 32'd6);
        dv_in = 1'b1; ad_in = 32'hDEAD_BEEF;
        @(negedge clock);
        chk_idle("t3_after");
        dv_in = 1'b0; ad_in = 32'd0;
        @(negedge clock);
        exp_q[0] = 32'h1234_5678;
        do_read(32'h5000_0FFC, 1, "t3_rd");

        // 4: out-of-window begin is ignored
        set_begin(1'b1); rnw = 1'b1; burst_in = 8'd3; be_in = 4'hF; ad_in = 32'h6000_0000;
        @(negedge clock);
        set_begin(1'b0); rnw = 1'b0; ad_in = 32'd0;
        for (int c = 0; c < 10; c++) begin
            chk_idle("t4_quiet");
            @(negedge clock);
        end
        exp_q[0] = 32'h11BB_11DD;
        do_read(32'h5000_0010, 1, "t4_rd");

        // 6: reset in the second beat of an 8-beat read keeps RAM contents
        for (int k = 0; k < 8; k++) exp_q[k] = 32'hC0DE_0000 + 32'(k);
        do_write(32'h5000_0020, 8, 4'hF, "t6_wr");
        set_begin(1'b1); rnw = 1'b1; burst_in = 8'd7; be_in = 4'hF; ad_in = 32'h5000_0020;
        @(negedge clock);
        set_begin(1'b0); rnw = 1'b0; ad_in = 32'd0;
        @(negedge clock);
        chk("t6_beat0", data_o, 32'hC0DE_0000);
        @(negedge clock);
        chk("t6_beat1", data_o, 32'hC0DE_0001);
        reset = 1'b1;
        @(negedge clock);
        chk_idle("t6_reset");
        reset = 1'b0;
        @(negedge clock);
        chk_idle("t6_post");
        do_read(32'h5000_0020, 8, "t6_rd");

        // 5: stall pattern every 2 beats on the second instance
        use_b = 1'b1;
        set_begin(1'b1); rnw = 1'b0; burst_in = 8'd5; be_in = 4'hF; ad_in = 32'h5000_0100;
        @(negedge clock);
        set_begin(1'b0);
        for (int c = 0; c < 8; c++) begin
            chk("t5_busy", {31'd0, busy_o}, {31'd0, busy_pat[c]});
            dv_in = 1'b1; ad_in = wdat[beat_tbl[c]]; end_in = (c == 7);
            @(negedge clock);
        end
        dv_in = 1'b0; end_in = 1'b0; ad_in = 32'd0;
        chk_idle("t5_idle");
        @(negedge clock);
        for (int k = 0; k < 6; k++) exp_q[k] = wdat[k];
        do_read(32'h5000_0100, 6, "t5_rd");
        use_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
